// File: rtl/data_mem_pkg.sv
// Shared types for the data-memory store buffer: entry layout and defaults.
package data_mem_pkg;

  localparam int SB_DEPTH_DEFAULT = 4;
  localparam int SB_ADDR_W        = 32;

  // One posted store: word address (byte offset dropped), lane enables, lane-aligned data.
  typedef struct packed {
    logic [SB_ADDR_W-3:0] word_addr;
    logic [3:0]           be;
    logic [31:0]          data;
  } sb_entry_t;

endpackage

// File: rtl/sb_hazard_cmp.sv
// Load-vs-pending-store overlap detector: one word-address comparator per entry,
// qualified by entry validity, OR-reduced into a single hazard flag.
module sb_hazard_cmp #(
  parameter int DEPTH = 4,
  parameter int WA_W  = 30
) (
  input  logic [DEPTH-1:0]      valid_i,
  input  logic [DEPTH*WA_W-1:0] word_addrs_i,
  input  logic                  check_i,
  input  logic [WA_W-1:0]       load_word_i,
  output logic                  hazard_o
);

  logic [DEPTH-1:0] hit;

  // Parallel compare of the load word against every valid entry.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = valid_i[i] && (word_addrs_i[i*WA_W +: WA_W] == load_word_i);
    end
  end

  assign hazard_o = check_i && (|hit);

endmodule

// File: rtl/data_mem_store_buffer.sv
// Posted-write FIFO between MEM-stage store formatting and the data memory port.
// Strict in-order drain over a valid/ready channel; flags loads hitting a pending store word.
module data_mem_store_buffer
  import data_mem_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH_DEFAULT,
  parameter int ADDR_W = SB_ADDR_W
) (
  input  logic                     Clk,
  input  logic                     Rst_N,
  input  logic                     Store_Valid,
  output logic                     Store_Ready,
  input  logic [ADDR_W-1:0]        Store_Addr,
  input  logic [3:0]               Write_Ctrl,
  input  logic [31:0]              Data_Mem_Write,
  output logic                     Mem_Req_Valid,
  input  logic                     Mem_Req_Ready,
  output logic [ADDR_W-1:0]        Mem_Addr,
  output logic [3:0]               Mem_Byte_En,
  output logic [31:0]              Mem_Wdata,
  input  logic                     Load_Check,
  input  logic [ADDR_W-1:0]        Load_Addr,
  output logic                     Load_Hazard,
  output logic                     Sb_Empty,
  output logic [$clog2(DEPTH):0]   Sb_Count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int WA_W  = ADDR_W - 2;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      count;
  sb_entry_t             mem_q [DEPTH];
  sb_entry_t             head;
  logic                  full, empty, push, pop;
  logic [DEPTH-1:0]      entry_valid;
  logic [DEPTH*WA_W-1:0] word_addrs;
  logic [IDX_W-1:0]      offset;
  logic                  unused_byte_offsets;

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                 (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // No full bypass: readiness depends only on registered occupancy.
  assign Store_Ready   = ~full;
  assign Mem_Req_Valid = ~empty;
  assign Sb_Empty      = empty;
  assign Sb_Count      = count;

  // A zero-byte-enable store completes the handshake but occupies no entry.
  assign push = Store_Valid && !full && (Write_Ctrl != 4'b0000);
  assign pop  = !empty && Mem_Req_Ready;

  // Head fields are forced to zero when nothing is pending.
  assign head        = mem_q[rd_ptr_q[IDX_W-1:0]];
  assign Mem_Addr    = empty ? '0 : {head.word_addr, 2'b00};
  assign Mem_Byte_En = empty ? '0 : head.be;
  assign Mem_Wdata   = empty ? '0 : head.data;

  assign unused_byte_offsets = ^{Store_Addr[1:0], Load_Addr[1:0]};

  // Next-state pointers; natural modulo wrap through the extra bit.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
  end

  // Pointer registers; reset discards every pending entry at once.
  always_ff @(posedge Clk or negedge Rst_N) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!Rst_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage write port.
  always_ff @(posedge Clk) begin
    // NOTE: storage is not reset; validity comes from the pointers, so stale contents are never visible.
    if (push) begin
      mem_q[wr_ptr_q[IDX_W-1:0]] <= '{word_addr: Store_Addr[ADDR_W-1:2],
                                      be:        Write_Ctrl,
                                      data:      Data_Mem_Write};
    end
  end

  // Entry i is valid when its distance from the head is below the occupancy.
  always_comb begin
    entry_valid = '0;
    word_addrs  = '0;
    offset      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset         = IDX_W'(i) - rd_ptr_q[IDX_W-1:0];
      entry_valid[i] = ({1'b0, offset} < count);
      word_addrs[i*WA_W +: WA_W] = mem_q[i].word_addr;
    end
  end

  sb_hazard_cmp #(
    .DEPTH (DEPTH),
    .WA_W  (WA_W)
  ) u_hazard (
    .valid_i      (entry_valid),
    .word_addrs_i (word_addrs),
    .check_i      (Load_Check),
    .load_word_i  (Load_Addr[ADDR_W-1:2]),
    .hazard_o     (Load_Hazard)
  );

endmodule

// File: tb/tb_data_mem_store_buffer.sv
// Directed self-checking bench for data_mem_store_buffer (DEPTH=4, ADDR_W=32).
module tb_data_mem_store_buffer;

  logic        Clk = 1'b0;
  logic        Rst_N;
  logic        Store_Valid;
  logic        Store_Ready;
  logic [31:0] Store_Addr;
  logic [3:0]  Write_Ctrl;
  logic [31:0] Data_Mem_Write;
  logic        Mem_Req_Valid;
  logic        Mem_Req_Ready;
  logic [31:0] Mem_Addr;
  logic [3:0]  Mem_Byte_En;
  logic [31:0] Mem_Wdata;
  logic        Load_Check;
  logic [31:0] Load_Addr;
  logic        Load_Hazard;
  logic        Sb_Empty;
  logic [2:0]  Sb_Count;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  data_mem_store_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
    .Clk            (Clk),
    .Rst_N          (Rst_N),
    .Store_Valid    (Store_Valid),
    .Store_Ready    (Store_Ready),
    .Store_Addr     (Store_Addr),
    .Write_Ctrl     (Write_Ctrl),
    .Data_Mem_Write (Data_Mem_Write),
    .Mem_Req_Valid  (Mem_Req_Valid),
    .Mem_Req_Ready  (Mem_Req_Ready),
    .Mem_Addr       (Mem_Addr),
    .Mem_Byte_En    (Mem_Byte_En),
    .Mem_Wdata      (Mem_Wdata),
    .Load_Check     (Load_Check),
    .Load_Addr      (Load_Addr),
    .Load_Hazard    (Load_Hazard),
    .Sb_Empty       (Sb_Empty),
    .Sb_Count       (Sb_Count)
  );

  // Advance one clock; observe 1ns after the rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic put_store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    Store_Valid    = 1'b1;
    Store_Addr     = a;
    Write_Ctrl     = be;
    Data_Mem_Write = d;
  endtask

  task automatic test_reset();
    Rst_N = 1'b0; Store_Valid = 1'b0; Store_Addr = '0; Write_Ctrl = '0; Data_Mem_Write = '0;
    Mem_Req_Ready = 1'b0; Load_Check = 1'b0; Load_Addr = '0;
    tick(); tick();
    Rst_N = 1'b1;
    tick();
    total++; if (Store_Ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", Store_Ready); end
    total++; if (Mem_Req_Valid !== 1'b0) begin bad++; $display("FAIL reset_reqv got=%b want=0", Mem_Req_Valid); end
    total++; if (Sb_Empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", Sb_Empty); end
    total++; if (Sb_Count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", Sb_Count); end
    total++; if (Mem_Addr !== 32'h0 || Mem_Wdata !== 32'h0 || Mem_Byte_En !== 4'h0) begin
      bad++; $display("FAIL reset_fields got=%h/%h/%h want=0/0/0", Mem_Addr, Mem_Byte_En, Mem_Wdata); end
  endtask

  task automatic test_single();
    Mem_Req_Ready = 1'b1;
    put_store(32'h0000_1003, 4'b1000, 32'hAB00_0000);
    tick();
    Store_Valid = 1'b0;
    total++; if (Mem_Req_Valid !== 1'b1) begin bad++; $display("FAIL single_reqv got=%b want=1", Mem_Req_Valid); end
    total++; if (Mem_Addr !== 32'h0000_1000) begin bad++; $display("FAIL single_addr got=%h want=00001000", Mem_Addr); end
    total++; if (Mem_Byte_En !== 4'b1000) begin bad++; $display("FAIL single_be got=%b want=1000", Mem_Byte_En); end
    total++; if (Mem_Wdata !== 32'hAB00_0000) begin bad++; $display("FAIL single_data got=%h want=ab000000", Mem_Wdata); end
    total++; if (Sb_Count !== 3'd1) begin bad++; $display("FAIL single_count got=%0d want=1", Sb_Count); end
    tick();
    total++; if (Sb_Empty !== 1'b1 || Mem_Req_Valid !== 1'b0) begin
      bad++; $display("FAIL single_drained got=empty%b/reqv%b want=1/0", Sb_Empty, Mem_Req_Valid); end
    total++; if (Mem_Addr !== 32'h0) begin bad++; $display("FAIL single_zero_addr got=%h want=0", Mem_Addr); end
  endtask

  task automatic test_fill_drain();
    Mem_Req_Ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put_store(32'h10 + 32'(4*i), 4'hF, 32'h1000 + 32'(i));
      tick();
    end
    total++; if (Store_Ready !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b want=0", Store_Ready); end
    total++; if (Sb_Count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d want=4", Sb_Count); end
    put_store(32'h20, 4'hF, 32'hDEAD);
    tick();
    total++; if (Sb_Count !== 3'd4) begin bad++; $display("FAIL fill_fifth_held got=%0d want=4", Sb_Count); end
    total++; if (Mem_Addr !== 32'h10 || Mem_Wdata !== 32'h1000) begin
      bad++; $display("FAIL fill_head_stable got=%h/%h want=00000010/00001000", Mem_Addr, Mem_Wdata); end
    Store_Valid = 1'b0;
    Mem_Req_Ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (Mem_Req_Valid !== 1'b1 || Mem_Addr !== 32'h10 + 32'(4*i) || Mem_Wdata !== 32'h1000 + 32'(i)) begin
        bad++; $display("FAIL drain_%0d got=v%b %h/%h want=v1 %h/%h", i, Mem_Req_Valid, Mem_Addr, Mem_Wdata,
                        32'h10 + 32'(4*i), 32'h1000 + 32'(i)); end
      tick();
    end
    total++; if (Sb_Empty !== 1'b1 || Sb_Count !== 3'd0) begin
      bad++; $display("FAIL drain_empty got=%b/%0d want=1/0", Sb_Empty, Sb_Count); end
  endtask

  task automatic test_full_simul();
    Mem_Req_Ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put_store(32'h40 + 32'(4*i), 4'hF, 32'h40 + 32'(i));
      tick();
    end
    total++; if (Sb_Count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d want=4", Sb_Count); end
    // Full: dequeue with a pending store must not admit the store this cycle.
    put_store(32'h80, 4'b0011, 32'h0000_8080);
    Mem_Req_Ready = 1'b1;
    tick();
    total++; if (Sb_Count !== 3'd3) begin bad++; $display("FAIL full_nobypass_count got=%0d want=3", Sb_Count); end
    total++; if (Mem_Addr !== 32'h44) begin bad++; $display("FAIL full_head1 got=%h want=00000044", Mem_Addr); end
    total++; if (Store_Ready !== 1'b1) begin bad++; $display("FAIL full_ready_back got=%b want=1", Store_Ready); end
    // Simultaneous enqueue and dequeue: occupancy held, the store lands in the wrapped slot.
    tick();
    Store_Valid = 1'b0;
    total++; if (Sb_Count !== 3'd3) begin bad++; $display("FAIL simul_count got=%0d want=3", Sb_Count); end
    total++; if (Mem_Addr !== 32'h48) begin bad++; $display("FAIL simul_head got=%h want=00000048", Mem_Addr); end
    tick();
    total++; if (Mem_Addr !== 32'h4C) begin bad++; $display("FAIL wrap_head2 got=%h want=0000004c", Mem_Addr); end
    tick();
    total++; if (Mem_Addr !== 32'h80 || Mem_Byte_En !== 4'b0011 || Mem_Wdata !== 32'h0000_8080) begin
      bad++; $display("FAIL wrap_entry got=%h/%b/%h want=00000080/0011/00008080", Mem_Addr, Mem_Byte_En, Mem_Wdata); end
    tick();
    total++; if (Sb_Empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b want=1", Sb_Empty); end
  endtask

  task automatic test_hazard();
    Mem_Req_Ready = 1'b0;
    put_store(32'h2000, 4'b0001, 32'h0000_00EE);
    tick();
    Store_Valid = 1'b0;
    Load_Check = 1'b1; Load_Addr = 32'h2002; #1;
    total++; if (Load_Hazard !== 1'b1) begin bad++; $display("FAIL hz_same_word got=%b want=1", Load_Hazard); end
    Load_Addr = 32'h2004; #1;
    total++; if (Load_Hazard !== 1'b0) begin bad++; $display("FAIL hz_next_word got=%b want=0", Load_Hazard); end
    Load_Check = 1'b0; Load_Addr = 32'h2000; #1;
    total++; if (Load_Hazard !== 1'b0) begin bad++; $display("FAIL hz_no_check got=%b want=0", Load_Hazard); end
    // Store being enqueued this cycle is not yet a hazard.
    Load_Check = 1'b1; Load_Addr = 32'h3001;
    put_store(32'h3000, 4'hF, 32'h3);
    #1;
    total++; if (Load_Hazard !== 1'b0) begin bad++; $display("FAIL hz_enq_same_cycle got=%b want=0", Load_Hazard); end
    tick();
    Store_Valid = 1'b0;
    total++; if (Load_Hazard !== 1'b1) begin bad++; $display("FAIL hz_second_entry got=%b want=1", Load_Hazard); end
    // Head being dequeued this cycle still counts.
    Load_Addr = 32'h2000; Mem_Req_Ready = 1'b1; #1;
    total++; if (Load_Hazard !== 1'b1) begin bad++; $display("FAIL hz_dequeue_head got=%b want=1", Load_Hazard); end
    tick();
    total++; if (Load_Hazard !== 1'b0) begin bad++; $display("FAIL hz_after_drain got=%b want=0", Load_Hazard); end
    tick();
    Load_Check = 1'b0;
    total++; if (Sb_Empty !== 1'b1) begin bad++; $display("FAIL hz_cleanup_empty got=%b want=1", Sb_Empty); end
  endtask

  task automatic test_reset_mid();
    Mem_Req_Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put_store(32'h500 + 32'(4*i), 4'hF, 32'h5 + 32'(i));
      tick();
    end
    Store_Valid = 1'b0;
    total++; if (Sb_Count !== 3'd3) begin bad++; $display("FAIL rmid_count got=%0d want=3", Sb_Count); end
    #2 Rst_N = 1'b0;
    #1;
    total++; if (Mem_Req_Valid !== 1'b0 || Sb_Count !== 3'd0 || Mem_Addr !== 32'h0) begin
      bad++; $display("FAIL rmid_async got=v%b c%0d a%h want=v0 c0 a0", Mem_Req_Valid, Sb_Count, Mem_Addr); end
    tick();
    Rst_N = 1'b1;
    Mem_Req_Ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (Mem_Req_Valid !== 1'b0) begin bad++; $display("FAIL rmid_no_req_%0d got=%b want=0", i, Mem_Req_Valid); end
    end
    // Zero byte enables: accepted but never enqueued.
    put_store(32'h600, 4'b0000, 32'h66);
    #1;
    total++; if (Store_Ready !== 1'b1) begin bad++; $display("FAIL zero_be_ready got=%b want=1", Store_Ready); end
    tick();
    Store_Valid = 1'b0;
    total++; if (Sb_Empty !== 1'b1 || Mem_Req_Valid !== 1'b0 || Sb_Count !== 3'd0) begin
      bad++; $display("FAIL zero_be_not_enq got=e%b v%b c%0d want=e1 v0 c0", Sb_Empty, Mem_Req_Valid, Sb_Count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_full_simul();
    test_hazard();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
